// File: rtl/donut_march.sv
// donut_march: iterative torus ray-march hit tester with per-hit shading.
// Latency: start is sampled on the first edge, and done rises on edge steps+2 (at most MAX_STEPS+2).
// Backpressure: none. start is sampled only in IDLE; while busy it is ignored and never queued.
//
// Ports: clk, rst_n (async, active low); start with px/py/pz, rx/ry/rz and lx/ly/lz, all latched
//        when start is accepted; busy and done status; hit, light, t_out and steps results.
//        The results update in the SHADE cycle and hold until the next job reaches SHADE.
module donut_march #(
  parameter int W         = 16,
  parameter int FRAC      = 8,
  parameter int R1        = 256,
  parameter int R2        = 512,
  parameter int MAX_STEPS = 8,
  parameter int T_INIT    = 512,
  parameter int T_MAX     = 2048,
  parameter int EPS       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic signed [W-1:0]            px_in,
  input  logic signed [W-1:0]            py_in,
  input  logic signed [W-1:0]            pz_in,
  input  logic signed [W-1:0]            rx_in,
  input  logic signed [W-1:0]            ry_in,
  input  logic signed [W-1:0]            rz_in,
  input  logic signed [W-1:0]            lx_in,
  input  logic signed [W-1:0]            ly_in,
  input  logic signed [W-1:0]            lz_in,
  output logic                           busy,
  output logic                           done,
  output logic                           hit,
  output logic signed [W-1:0]            light,
  output logic signed [W-1:0]            t_out,
  output logic [$clog2(MAX_STEPS+1)-1:0] steps
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MARCH = 2'd1;
  localparam logic [1:0] S_SHADE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [W-1:0] R1_W     = W'(R1);
  localparam logic signed [W-1:0] R2_W     = W'(R2);
  localparam logic signed [W-1:0] T_INIT_W = W'(T_INIT);
  localparam logic signed [W:0]   T_MAX_X  = (W+1)'(T_MAX);
  localparam logic signed [W:0]   EPS_X    = (W+1)'(EPS);
  localparam logic [SW-1:0]       CAP      = SW'(MAX_STEPS);

  // Two-step vectoring CORDIC. Returns {magnitude, x2out}; the companion
  // vector (x2,y2) goes through the same folds and rotations, so x2out is
  // the light component along the surface-normal direction.
  // Folding (|x|, |y|, swap) brings the vector into the first octant
  // exactly. A rotation is applied only while y is nonzero, so on-axis
  // inputs return their exact magnitude. Each applied rotation is
  // immediately rescaled by 1-2^-(2i+1) to undo most of its CORDIC gain.
  function automatic logic [2*W-1:0] cordic2step(
    input logic signed [W-1:0] xi,
    input logic signed [W-1:0] yi,
    input logic signed [W-1:0] x2i,
    input logic signed [W-1:0] y2i
  );
    logic signed [W-1:0] x, y, a, b, xo, ao;
    x  = xi;
    y  = yi;
    a  = x2i;
    b  = y2i;
    xo = '0;
    ao = '0;
    if (x < 0) begin
      x = -x;
      a = -a;
    end
    if (y < 0) begin
      y = -y;
      b = -b;
    end
    if (y > x) begin
      xo = x; x = y; y = xo;
      ao = a; a = b; b = ao;
    end
    for (int i = 1; i <= 2; i++) begin
      if (y != 0) begin
        xo = x;
        ao = a;
        if (y > 0) begin
          x = x + (y >>> i);
          y = y - (xo >>> i);
          a = a + (b >>> i);
          b = b - (ao >>> i);
        end else begin
          x = x - (y >>> i);
          y = y + (xo >>> i);
          a = a - (b >>> i);
          b = b + (ao >>> i);
        end
        x = x - (x >>> (2*i + 1));
        y = y - (y >>> (2*i + 1));
        a = a - (a >>> (2*i + 1));
        b = b - (b >>> (2*i + 1));
      end
    end
    return {x, a};
  endfunction

  logic [1:0]          state;
  logic signed [W-1:0] px, py, pz, rx, ry, rz, lx, ly, lz, t;
  logic [SW-1:0]       cnt;
  logic                hit_r;

  // Distance estimate at the current point, evaluated every cycle.
  logic signed [W-1:0] t0, l1, t1, t2, l2, d;
  always_comb begin
    {t0, l1} = cordic2step(px, py, lx, ly);
    t1       = t0 - R2_W;
    {t2, l2} = cordic2step(pz, t1, lz, l1);
    d        = t2 - R1_W;
  end

  // One extra bit so |d| of the most negative value and t+d never wrap
  // before the convergence and escape compares.
  logic signed [W:0] d_x, abs_d, tsum;
  assign d_x   = {d[W-1], d};
  assign abs_d = d[W-1] ? -d_x : d_x;
  assign tsum  = $signed({t[W-1], t}) + d_x;

  logic conv, esc;
  assign conv = (EPS > 0) && (abs_d < EPS_X);
  assign esc  = (tsum >= T_MAX_X);

  logic signed [2*W-1:0] prod_x, prod_y, prod_z;
  logic signed [W-1:0]   step_x, step_y, step_z;
  assign prod_x = $signed({{W{d[W-1]}}, d}) * $signed({{W{rx[W-1]}}, rx});
  assign prod_y = $signed({{W{d[W-1]}}, d}) * $signed({{W{ry[W-1]}}, ry});
  assign prod_z = $signed({{W{d[W-1]}}, d}) * $signed({{W{rz[W-1]}}, rz});
  assign step_x = W'(prod_x >>> FRAC);
  assign step_y = W'(prod_y >>> FRAC);
  assign step_z = W'(prod_z >>> FRAC);

  logic [SW-1:0] cnt_nxt;
  assign cnt_nxt = cnt + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      px    <= '0; py <= '0; pz <= '0;
      rx    <= '0; ry <= '0; rz <= '0;
      lx    <= '0; ly <= '0; lz <= '0;
      t     <= '0;
      cnt   <= '0;
      hit_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hit   <= 1'b0;
      light <= '0;
      t_out <= '0;
      steps <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            px    <= px_in; py <= py_in; pz <= pz_in;
            rx    <= rx_in; ry <= ry_in; rz <= rz_in;
            lx    <= lx_in; ly <= ly_in; lz <= lz_in;
            t     <= T_INIT_W;
            cnt   <= '0;
            hit_r <= 1'b0;
            busy  <= 1'b1;
            state <= S_MARCH;
          end
        end
        S_MARCH: begin
          cnt <= cnt_nxt;
          if (conv) begin
            hit_r <= 1'b1;
            state <= S_SHADE;
          end else if (esc) begin
            hit_r <= 1'b0;
            t     <= tsum[W-1:0];
            state <= S_SHADE;
          end else begin
            t  <= tsum[W-1:0];
            px <= px + step_x;
            py <= py + step_y;
            pz <= pz + step_z;
            // Running out of steps without escaping counts as a hit.
            if (cnt_nxt == CAP) begin
              hit_r <= 1'b1;
              state <= S_SHADE;
            end
          end
        end
        S_SHADE: begin
          light <= l2;
          t_out <= t;
          steps <= cnt;
          hit   <= hit_r;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
